uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; power of two, 2..256.
REQ-002 Parameter DW, default 8, data width; matches receiver DBIT.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr  input  1  write strobe, driven by receiver rx_done_tick, one cycle per byte.
REQ-006 din  input  DW  received byte, sampled when wr=1.
REQ-007 rd  input  1  read/pop strobe from consumer.
REQ-008 dout  output  DW  head entry, first-word fall-through.
REQ-009 empty  output  1  no stored entries.
REQ-010 full  output  1  DEPTH entries stored.
REQ-011 overrun  output  1  sticky: a byte was dropped.
REQ-012 clr_ovr  input  1  clears overrun.
REQ-013 level  output  $clog2(DEPTH)+1  entry count; present only with UART_RX_FIFO_LEVEL_EN.

Function
REQ-014 Write accepted when wr=1 and (full=0 or a read is accepted the same cycle); din stored at write pointer; pointer increments.
REQ-015 Read accepted when rd=1 and empty=0; read pointer increments.
REQ-016 rd with empty=1 ignored; no pointer change, no error flag.
REQ-017 wr with full=1 and no accepted read: byte dropped, contents unchanged, overrun=1 from next cycle.
REQ-018 wr and rd same cycle, empty=1: write accepted, read ignored; empty=0 next cycle.
REQ-019 wr and rd same cycle, full=1: both accepted, full stays 1, overrun unchanged.
REQ-020 wr and rd same cycle, otherwise: both accepted, occupancy unchanged.
REQ-021 dout = entry at read pointer, combinational from storage; valid whenever empty=0; undefined-but-stable when empty=1.
REQ-022 Write-to-read latency: byte written in cycle N visible on dout, empty=0, in cycle N+1.
REQ-023 Pointers $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH; empty = pointers equal; full = index bits equal, MSBs differ.
REQ-024 full, empty registered-equivalent: derived only from pointer registers, never from same-cycle inputs.
REQ-025 overrun set and clr_ovr same cycle: set wins, overrun=1.
REQ-026 clr_ovr alone: overrun=0 next cycle; stored data unaffected.

Reset
REQ-027 reset=1 at rising edge: both pointers 0, empty=1, full=0, overrun=0, level=0 next cycle.
REQ-028 Reset has priority over wr, rd, clr_ovr same cycle.
REQ-029 Reset mid-operation discards all stored bytes; storage array itself not reset.

Configuration
REQ-030 Macro UART_RX_FIFO_LEVEL_EN defined: level port present, equals write pointer minus read pointer modulo 2*DEPTH, updates with pointers.
REQ-031 Macro undefined: level port and its logic absent; all other behaviour identical.

Structure
REQ-032 Shared package uart_pkg holds DBIT default (8), SB_TICK default (16), and FIFO depth default constant; receiver and this block both import it.
REQ-033 Storage in one sub-module uart_fifo_ram: DEPTH x DW, single synchronous write port, asynchronous read port.
REQ-034 Pointer, flag, overrun logic in uart_rx_fifo; no state machine beyond pointer registers and overrun flop.

Verification
REQ-035 Reset, write 0x41,0x42,0x43 on separate cycles -> dout=0x41 one cycle after first write; three reads return 0x41,0x42,0x43; empty=1 after third.
REQ-036 DEPTH=16: write 16 bytes 0x00..0x0F -> full=1; 17th write 0xFF -> dropped, overrun=1; 16 reads return 0x00..0x0F only.
REQ-037 Full FIFO, wr=1 din=0x55 and rd=1 same cycle -> full stays 1, overrun 0, 0x55 is last byte read.
REQ-038 Empty FIFO, wr=1 din=0xA5 and rd=1 same cycle -> empty=0 next cycle, dout=0xA5.
REQ-039 overrun=1, clr_ovr=1 with a dropped write same cycle -> overrun stays 1; clr_ovr alone next cycle -> overrun=0.
REQ-040 Five bytes stored, reset=1 with wr=1 -> next cycle empty=1, level=0 (macro defined), subsequent read sees no stale data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver and its output FIFO.
package uart_pkg;

  localparam int DBIT       = 8;   // data bits per frame
  localparam int SB_TICK    = 16;  // oversampling ticks per stop bit
  localparam int FIFO_DEPTH = 16;  // default receive FIFO depth

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: DEPTH x DW, one synchronous write port, one asynchronous read port.
module uart_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with first-word fall-through output and sticky overrun flag.
// Define UART_RX_FIFO_LEVEL_EN to add the occupancy (level) output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int DW    = DBIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr,
  input  logic [DW-1:0]          din,
  input  logic                   rd,
  output logic [DW-1:0]          dout,
  output logic                   empty,
  output logic                   full,
  output logic                   overrun,
  input  logic                   clr_ovr
`ifdef UART_RX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        rd_ok;
  logic        wr_ok;
  logic        drop;

  // Flags come from pointer registers only; the extra MSB separates full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);
  assign drop  = wr & ~wr_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // A drop in the same cycle as clr_ovr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok & ~reset),
    .waddr (wptr[AW-1:0]),
    .wdata (din),
    .raddr (rptr[AW-1:0]),
    .rdata (dout)
  );

`ifdef UART_RX_FIFO_LEVEL_EN
  assign level = wptr - rptr;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, DW=8).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = '0;
  logic       rd = 1'b0;
  logic       clr_ovr = 1'b0;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       overrun;
`ifdef UART_RX_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH (16),
    .DW    (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr),
    .din     (din),
    .rd      (rd),
    .dout    (dout),
    .empty   (empty),
    .full    (full),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr = 1'b0; rd = 1'b0; clr_ovr = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset;
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic fill(input int unsigned n, input logic [7:0] base);
    for (int unsigned i = 0; i < n; i++) begin
      wr = 1'b1; din = base + i[7:0];
      step();
    end
    wr = 1'b0;
  endtask

  task automatic test_reset;
    wr = 1'b1; din = 8'h11; rd = 1'b1; clr_ovr = 1'b1;
    reset = 1'b1;
    step();
    idle();
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: empty=%b full=%b overrun=%b, expected 1 0 0", empty, full, overrun);
    end
`ifdef UART_RX_FIFO_LEVEL_EN
    checks++;
    if (level !== 5'd0) begin
      failures++;
      $display("FAIL reset_level: got %0d expected 0", level);
    end
`endif
  endtask

  task automatic test_basic;
    logic [7:0] exp_bytes [3];
    exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h42; exp_bytes[2] = 8'h43;
    do_reset();
    wr = 1'b1; din = 8'h41;
    step();
    wr = 1'b0;
    checks++;
    if (dout !== 8'h41 || empty !== 1'b0) begin
      failures++;
      $display("FAIL basic_latency: dout=%h empty=%b, expected 41 0", dout, empty);
    end
    wr = 1'b1; din = 8'h42; step();
    wr = 1'b1; din = 8'h43; step();
    wr = 1'b0;
    rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dout !== exp_bytes[i]) begin
        failures++;
        $display("FAIL basic_read%0d: got %h expected %h", i, dout, exp_bytes[i]);
      end
      step();
    end
    rd = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL basic_empty: empty=%b expected 1", empty);
    end
  endtask

  task automatic test_empty_read;
    do_reset();
    rd = 1'b1; step(); rd = 1'b0;
    wr = 1'b1; din = 8'h3C; step(); wr = 1'b0;
    checks++;
    if (dout !== 8'h3C || empty !== 1'b0 || full !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL empty_read_ignored: dout=%h empty=%b full=%b ovr=%b, expected 3c 0 0 0",
               dout, empty, full, overrun);
    end
  endtask

  task automatic test_full_overrun;
    do_reset();
    fill(16, 8'h00);
    checks++;
    if (full !== 1'b1 || empty !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL full_flag: full=%b empty=%b ovr=%b, expected 1 0 0", full, empty, overrun);
    end
`ifdef UART_RX_FIFO_LEVEL_EN
    checks++;
    if (level !== 5'd16) begin
      failures++;
      $display("FAIL full_level: got %0d expected 16", level);
    end
`endif
    wr = 1'b1; din = 8'hFF; step(); wr = 1'b0;
    checks++;
    if (overrun !== 1'b1 || full !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: ovr=%b full=%b, expected 1 1", overrun, full);
    end
    rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dout !== i[7:0]) begin
        failures++;
        $display("FAIL full_read%0d: got %h expected %h", i, dout, i[7:0]);
      end
      step();
    end
    rd = 1'b0;
    checks++;
    if (empty !== 1'b1 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL full_drain: empty=%b ovr=%b, expected 1 1", empty, overrun);
    end
  endtask

  task automatic test_full_rw;
    do_reset();
    fill(16, 8'h00);
    wr = 1'b1; din = 8'h55; rd = 1'b1;
    step();
    idle();
    checks++;
    if (full !== 1'b1 || overrun !== 1'b0 || dout !== 8'h01) begin
      failures++;
      $display("FAIL full_rw: full=%b ovr=%b dout=%h, expected 1 0 01", full, overrun, dout);
    end
    rd = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] e;
      e = (i == 16) ? 8'h55 : i[7:0];
      checks++;
      if (dout !== e) begin
        failures++;
        $display("FAIL full_rw_read%0d: got %h expected %h", i, dout, e);
      end
      step();
    end
    rd = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL full_rw_empty: empty=%b expected 1", empty);
    end
  endtask

  task automatic test_empty_rw;
    do_reset();
    wr = 1'b1; din = 8'hA5; rd = 1'b1;
    step();
    idle();
    checks++;
    if (empty !== 1'b0 || dout !== 8'hA5) begin
      failures++;
      $display("FAIL empty_rw: empty=%b dout=%h, expected 0 a5", empty, dout);
    end
`ifdef UART_RX_FIFO_LEVEL_EN
    checks++;
    if (level !== 5'd1) begin
      failures++;
      $display("FAIL empty_rw_level: got %0d expected 1", level);
    end
`endif
  endtask

  task automatic test_overrun_clear;
    do_reset();
    fill(16, 8'h20);
    wr = 1'b1; din = 8'hEE; step(); wr = 1'b0;
    wr = 1'b1; din = 8'hEF; clr_ovr = 1'b1;
    step();
    idle();
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_set_wins: got %b expected 1", overrun);
    end
    clr_ovr = 1'b1;
    step();
    idle();
    checks++;
    if (overrun !== 1'b0 || full !== 1'b1 || dout !== 8'h20) begin
      failures++;
      $display("FAIL ovr_clear: ovr=%b full=%b dout=%h, expected 0 1 20", overrun, full, dout);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    fill(5, 8'h10);
    wr = 1'b1; din = 8'h99; rd = 1'b1; reset = 1'b1;
    step();
    idle();
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_flags: empty=%b full=%b, expected 1 0", empty, full);
    end
`ifdef UART_RX_FIFO_LEVEL_EN
    checks++;
    if (level !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid_level: got %0d expected 0", level);
    end
`endif
    rd = 1'b1; step(); rd = 1'b0;
    wr = 1'b1; din = 8'h77; step(); wr = 1'b0;
    checks++;
    if (dout !== 8'h77 || empty !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_stale: dout=%h empty=%b, expected 77 0", dout, empty);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_empty_read();
    test_full_overrun();
    test_full_rw();
    test_empty_rw();
    test_overrun_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
